// File: rtl/capture_ctl.sv
// Capture engine: subsamples the stream, then runs arm/trigger/delay/post-count and ends with tlast.
// Optional per-beat acceptance timestamp output enabled by CAPTURE_CTL_TSTAMP_EN.
module capture_ctl #(
  parameter int SDW = 32,
  parameter int SCW = 32,
  parameter int SNW = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [SCW-1:0] cfg_div,
  input  logic [SNW-1:0] cfg_dly,
  input  logic [SNW-1:0] cfg_cnt,
  input  logic           ctl_arm,
  input  logic           ctl_abort,
  output logic           sts_armed,
  output logic           sts_trg,
  output logic           sts_done,
  output logic           sti_tready,
  input  logic           sti_tvalid,
  input  logic           sti_trigger,
  input  logic [SDW-1:0] sti_tdata,
  input  logic           sto_tready,
  output logic           sto_tvalid,
  output logic           sto_tlast,
  output logic           sto_trigger,
`ifdef CAPTURE_CTL_TSTAMP_EN
  output logic [SNW-1:0] sto_tstamp,
`endif
  output logic [SDW-1:0] sto_tdata
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_DELAY = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [SCW-1:0] SC_ZERO = {SCW{1'b0}};
  localparam logic [SCW-1:0] SC_ONE  = {{(SCW-1){1'b0}}, 1'b1};
  localparam logic [SNW-1:0] SN_ZERO = {SNW{1'b0}};
  localparam logic [SNW-1:0] SN_ONE  = {{(SNW-1){1'b0}}, 1'b1};

  state_t         state_r, state_nx_s;
  logic [SCW-1:0] cfg_div_r, div_cnt_r;
  logic [SNW-1:0] cfg_dly_r, cfg_cnt_r, dly_cnt_r, post_cnt_r;
  logic           trg_pend_r;
  logic           sts_armed_r, sts_trg_r, sts_done_r;
  logic           sto_tvalid_r, sto_tlast_r, sto_trigger_r;
  logic [SDW-1:0] sto_tdata_r;
  logic           acc_s, active_s, keep_s, trg_hit_s;
  logic           arm_s, mark_s, last_s, to_dly_s, to_post_s;
`ifdef CAPTURE_CTL_TSTAMP_EN
  logic [SNW-1:0] ts_cnt_r, sto_tstamp_r;
  assign sto_tstamp = sto_tstamp_r;
`endif

  assign sti_tready  = !sto_tvalid_r | sto_tready;
  assign acc_s       = sti_tvalid & sti_tready;
  assign active_s    = (state_r == ST_ARMED) | (state_r == ST_DELAY) | (state_r == ST_POST);
  // Abort suppresses the beat accepted in the same cycle so nothing new enters the slice.
  assign keep_s      = acc_s & active_s & (div_cnt_r == SC_ZERO) & !ctl_abort;
  assign trg_hit_s   = trg_pend_r | sti_trigger;

  assign sts_armed   = sts_armed_r;
  assign sts_trg     = sts_trg_r;
  assign sts_done    = sts_done_r;
  assign sto_tvalid  = sto_tvalid_r;
  assign sto_tlast   = sto_tlast_r;
  assign sto_trigger = sto_trigger_r;
  assign sto_tdata   = sto_tdata_r;

  // Next-state and per-beat marker/last decode
  always_comb begin
    state_nx_s = state_r;
    arm_s      = 1'b0;
    mark_s     = 1'b0;
    last_s     = 1'b0;
    to_dly_s   = 1'b0;
    to_post_s  = 1'b0;
    if (ctl_abort) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (ctl_arm) begin
            arm_s      = 1'b1;
            state_nx_s = ST_ARMED;
          end else begin
            state_nx_s = state_r;
          end
        end
        ST_ARMED: begin
          if (keep_s && trg_hit_s) begin
            if (cfg_dly_r == SN_ZERO) begin
              mark_s = 1'b1;
            end else begin
              to_dly_s   = 1'b1;
              state_nx_s = ST_DELAY;
            end
          end else begin
            state_nx_s = state_r;
          end
        end
        ST_DELAY: begin
          if (keep_s && (dly_cnt_r == SN_ONE)) begin
            mark_s = 1'b1;
          end else begin
            state_nx_s = state_r;
          end
        end
        ST_POST: begin
          // The beat that takes post_cnt to zero closes the capture.
          if (keep_s && (post_cnt_r == SN_ONE)) begin
            last_s     = 1'b1;
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = state_r;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase
      if (mark_s) begin
        if (cfg_cnt_r == SN_ZERO) begin
          last_s     = 1'b1;
          state_nx_s = ST_DONE;
        end else begin
          to_post_s  = 1'b1;
          state_nx_s = ST_POST;
        end
      end else begin
        to_post_s = 1'b0;
      end
    end
  end

  // State register, status flags and capture counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cfg_div_r   <= SC_ZERO;
      cfg_dly_r   <= SN_ZERO;
      cfg_cnt_r   <= SN_ZERO;
      div_cnt_r   <= SC_ZERO;
      dly_cnt_r   <= SN_ZERO;
      post_cnt_r  <= SN_ZERO;
      trg_pend_r  <= 1'b0;
      sts_armed_r <= 1'b0;
      sts_trg_r   <= 1'b0;
      sts_done_r  <= 1'b0;
`ifdef CAPTURE_CTL_TSTAMP_EN
      ts_cnt_r    <= SN_ZERO;
`endif
    end else begin
      state_r     <= state_nx_s;
      sts_armed_r <= (state_nx_s == ST_ARMED) | (state_nx_s == ST_DELAY) | (state_nx_s == ST_POST);
      sts_done_r  <= (state_nx_s == ST_DONE);
      if (arm_s) begin
        cfg_div_r  <= cfg_div;
        cfg_dly_r  <= cfg_dly;
        cfg_cnt_r  <= cfg_cnt;
        div_cnt_r  <= SC_ZERO;
        dly_cnt_r  <= SN_ZERO;
        post_cnt_r <= SN_ZERO;
        trg_pend_r <= 1'b0;
        sts_trg_r  <= 1'b0;
`ifdef CAPTURE_CTL_TSTAMP_EN
        ts_cnt_r   <= SN_ZERO;
`endif
      end else if (ctl_abort) begin
        trg_pend_r <= 1'b0;
      end else begin
        if (acc_s && active_s) begin
          div_cnt_r <= (div_cnt_r == SC_ZERO) ? cfg_div_r : (div_cnt_r - SC_ONE);
`ifdef CAPTURE_CTL_TSTAMP_EN
          ts_cnt_r  <= ts_cnt_r + SN_ONE;
`endif
        end
        if ((state_r == ST_ARMED) && keep_s && trg_hit_s) begin
          trg_pend_r <= 1'b0;
        end else if ((state_r == ST_ARMED) && acc_s && sti_trigger) begin
          trg_pend_r <= 1'b1;
        end
        if (to_dly_s) begin
          dly_cnt_r <= cfg_dly_r;
        end else if (keep_s && (state_r == ST_DELAY)) begin
          dly_cnt_r <= dly_cnt_r - SN_ONE;
        end
        if (to_post_s) begin
          post_cnt_r <= cfg_cnt_r;
        end else if (keep_s && (state_r == ST_POST)) begin
          post_cnt_r <= post_cnt_r - SN_ONE;
        end
        if (mark_s) begin
          sts_trg_r <= 1'b1;
        end
      end
    end
  end

  // Output register slice; payload holds until the downstream takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sto_tvalid_r  <= 1'b0;
      sto_tlast_r   <= 1'b0;
      sto_trigger_r <= 1'b0;
      sto_tdata_r   <= {SDW{1'b0}};
`ifdef CAPTURE_CTL_TSTAMP_EN
      sto_tstamp_r  <= SN_ZERO;
`endif
    end else if (keep_s) begin
      sto_tvalid_r  <= 1'b1;
      sto_tlast_r   <= last_s;
      sto_trigger_r <= mark_s;
      sto_tdata_r   <= sti_tdata;
`ifdef CAPTURE_CTL_TSTAMP_EN
      sto_tstamp_r  <= ts_cnt_r;
`endif
    end else if (sto_tready) begin
      sto_tvalid_r  <= 1'b0;
    end
  end

endmodule
